// File: rtl/ram_scan_if.sv
// Bundle of the scan reader's control, RAM-side and display-side signals.
// The slave modport is the reader; the master modport is its environment.
interface ram_scan_if #(
    parameter int ADDR_W = 4,
    parameter int DATA_W = 8
);
    logic              en;
    logic              step;
    logic              ram_we;
    logic [DATA_W-1:0] ram_dout;
    logic [ADDR_W-1:0] outaddr;
    logic [ADDR_W-1:0] cur_addr;
    logic [DATA_W-1:0] cur_data;
    logic              valid;
    logic [6:0]        hex0;
    logic [6:0]        hex1;
    logic [6:0]        hex2;

    modport slave (
        input  en, step, ram_we, ram_dout,
        output outaddr, cur_addr, cur_data, valid, hex0, hex1, hex2
    );

    modport master (
        output en, step, ram_we, ram_dout,
        input  outaddr, cur_addr, cur_data, valid, hex0, hex1, hex2
    );
endinterface

// File: rtl/ram_scan_reader.sv
// Scans a synchronous-read RAM address by address (auto dwell or manual step),
// holding each captured word and its address for the 7-segment display.
module ram_scan_reader #(
    parameter int ADDR_W    = 4,
    parameter int DATA_W    = 8,
    parameter int LAST_ADDR = 15,
    parameter int DWELL     = 25000000
) (
    input  logic clk,
    input  logic clrn,
    ram_scan_if.slave bus
);
    localparam int                CW         = (DWELL > 1) ? $clog2(DWELL) : 1;
    localparam logic [CW-1:0]     DWELL_LAST = CW'(DWELL - 1);
    localparam logic [ADDR_W-1:0] ADDR_LAST  = ADDR_W'(LAST_ADDR);

    typedef enum logic [1:0] {IDLE, ISSUE, CAPTURE, HOLD} state_t;

    state_t            state, state_nx;
    logic [ADDR_W-1:0] addr;
    logic [CW-1:0]     cnt;
    logic              step_q;
    logic              step_rise;
    logic [ADDR_W-1:0] cur_addr_r;
    logic [DATA_W-1:0] cur_data_r;
    logic              valid_r;
    logic              do_start, do_advance, do_capture, cnt_inc, cnt_clr;

    function automatic logic [ADDR_W-1:0] next_addr(input logic [ADDR_W-1:0] a);
        return (a == ADDR_LAST) ? '0 : a + ADDR_W'(1);
    endfunction

    function automatic logic [6:0] seg7(input logic [3:0] v);
        case (v)
            4'h0:    return 7'b1000000;
            4'h1:    return 7'b1111001;
            4'h2:    return 7'b0100100;
            4'h3:    return 7'b0110000;
            4'h4:    return 7'b0011001;
            4'h5:    return 7'b0010010;
            4'h6:    return 7'b0000010;
            4'h7:    return 7'b1111000;
            4'h8:    return 7'b0000000;
            4'h9:    return 7'b0010000;
            4'hA:    return 7'b0001000;
            4'hB:    return 7'b0000011;
            4'hC:    return 7'b1000110;
            4'hD:    return 7'b0100001;
            4'hE:    return 7'b0000110;
            default: return 7'b0001110;
        endcase
    endfunction

    assign step_rise = bus.step & ~step_q;

    always_ff @(posedge clk or negedge clrn) begin
        if (!clrn) state <= IDLE;
        else       state <= state_nx;
    end

    always_comb begin
        state_nx   = state;
        do_start   = 1'b0;
        do_advance = 1'b0;
        do_capture = 1'b0;
        cnt_inc    = 1'b0;
        cnt_clr    = 1'b0;
        case (state)
            IDLE: begin
                if (bus.en || step_rise) begin
                    do_start = 1'b1;
                    state_nx = ISSUE;
                end
            end
            // The RAM only reads on an edge where its write enable is low.
            ISSUE: begin
                if (!bus.ram_we) state_nx = CAPTURE;
            end
            CAPTURE: begin
                do_capture = 1'b1;
                cnt_clr    = 1'b1;
                state_nx   = HOLD;
            end
            HOLD: begin
                // A step edge wins over the dwell count so only one advance happens.
                if (step_rise || (bus.en && cnt == DWELL_LAST)) begin
                    do_advance = 1'b1;
                    cnt_clr    = 1'b1;
                    state_nx   = ISSUE;
                end else if (bus.en) begin
                    cnt_inc = 1'b1;
                end else begin
                    cnt_clr = 1'b1;
                end
            end
            default: state_nx = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge clrn) begin
        if (!clrn) begin
            step_q     <= 1'b0;
            addr       <= '0;
            cnt        <= '0;
            cur_addr_r <= '0;
            cur_data_r <= '0;
            valid_r    <= 1'b0;
        end else begin
            step_q <= bus.step;
            if (do_start)        addr <= '0;
            else if (do_advance) addr <= next_addr(addr);
            if (cnt_clr)         cnt <= '0;
            else if (cnt_inc)    cnt <= cnt + CW'(1);
            if (do_capture) begin
                cur_data_r <= bus.ram_dout;
                cur_addr_r <= addr;
                valid_r    <= 1'b1;
            end
        end
    end

    assign bus.outaddr  = addr;
    assign bus.cur_addr = cur_addr_r;
    assign bus.cur_data = cur_data_r;
    assign bus.valid    = valid_r;
    assign bus.hex0     = seg7(cur_data_r[3:0]);
    assign bus.hex1     = seg7(cur_data_r[7:4]);
    assign bus.hex2     = seg7(4'(cur_addr_r));
endmodule

// File: doc/ram_scan_reader.md
Name: ram_scan_reader

Overview:
- Downstream consumer of the 16x8 synchronous-read RAM block.
- Drives the RAM read address and steps through addresses 0..LAST_ADDR, either automatically at a programmable dwell rate or one address per step pulse.
- Captures each registered RAM output and holds it, with its address, for the seven-segment display stage on the board.
- Respects the RAM's rule that a read only happens on a clock edge where its write enable is low.

Parameters:
- ADDR_W, 4, width of the RAM address.
- DATA_W, 8, width of the RAM data.
- LAST_ADDR, 15, highest address scanned before wrapping to 0.
- DWELL, 25000000, clock cycles spent in HOLD per address in auto mode; must be ≥1.

Ports:
- clk  input  1  system clock, rising edge.
- clrn  input  1  asynchronous active-low reset.
- en  input  1  auto-scan enable, level.
- step  input  1  manual advance request, synchronous level; acts on its rising edge only.
- ram_we  input  1  write enable currently presented to the RAM; a high value blocks the RAM read.
- ram_dout  input  DATA_W  registered read data from the RAM.
- outaddr  output  ADDR_W  read address to the RAM, registered.
- cur_addr  output  ADDR_W  address of the held data.
- cur_data  output  DATA_W  held RAM data.
- valid  output  1  high once cur_data holds a real read.
- hex0  output  7  active-low 7-seg pattern, cur_data[3:0].
- hex1  output  7  active-low 7-seg pattern, cur_data[7:4].
- hex2  output  7  active-low 7-seg pattern, cur_addr.

Behaviour:
- **Reset (clrn low, asynchronous, any state):**
  - state=IDLE; addr, outaddr, cur_addr, cur_data, dwell counter and step edge register cleared to 0; valid=0.
  - hex0, hex1, hex2 = 7'b1000000 ("0").
- **Step edge:** step_rise = step & ~step_q, where step_q is step registered each cycle.
- **Address register:** outaddr always equals the internal addr register.
- **State IDLE:**
  - en=1 or step_rise goes to ISSUE with addr=0.
  - Otherwise stay in IDLE.
- **State ISSUE:** outaddr is stable.
  - If ram_we=0 at the edge, the RAM loads dout; go to CAPTURE.
  - If ram_we=1, stay in ISSUE and retry each cycle until ram_we=0. There is no timeout.
- **State CAPTURE (exactly 1 cycle):**
  - At the closing edge: cur_data<=ram_dout, cur_addr<=addr, valid<=1.
  - Clear the dwell counter and go to HOLD.
- **Read latency:** 2 clocks from ISSUE entry to cur_data update when there is no write conflict.
- **State HOLD:**
  - en=1: the counter increments each cycle. When it reaches DWELL-1, advance addr and go to ISSUE.
  - en=0: the counter is held at 0. step_rise advances addr and goes to ISSUE.
  - en=1 and step_rise in the same cycle: step_rise advances immediately and the counter clears. Exactly one advance occurs, never two.
- **Advance rule:** addr = (addr==LAST_ADDR) ? 0 : addr+1. The wrap is on LAST_ADDR, not on 2^ADDR_W.
- **step_rise outside IDLE/HOLD:** ignored, not queued.
- **en falling mid-dwell:** the counter clears and HOLD waits for step. en rising again restarts the full DWELL count.
- **Output stability:** cur_data and cur_addr change only at the CAPTURE edge. They stay stable during ISSUE retries and during HOLD.
- **Hex decode:**
  - Combinational from the registered cur_data and cur_addr.
  - Standard hex 0-F, active-low, segment order gfedcba.
  - Examples: 0=7'b1000000, 5=7'b0010010, A=7'b0001000, F=7'b0001110.
- **Other:** no arithmetic beyond the address increment and the dwell counter. Counter width is clog2(DWELL) with a minimum of 1.

Test Plan (DWELL=4, LAST_ADDR=15; RAM model preloaded with mem[i]=8'h10+i):
- Reset then en=1 at cycle 0 → outaddr=0. After 2 cycles: cur_data=8'h10, cur_addr=0, valid=1, hex1=7'b1111001, hex0=7'b1000000.
- en=1 held for the full sweep → addresses 0..15 each captured; consecutive captures are 6 cycles apart (ISSUE + CAPTURE + 4 HOLD). After addr 15 (8'h1F) the next capture is addr 0 (8'h10).
- ram_we=1 for 3 cycles starting at ISSUE of addr 3 → 3 extra ISSUE cycles. cur_data stays 8'h12 until ram_we falls, then becomes 8'h13 two cycles later.
- en=0 in HOLD at addr 5; step pulsed high for 4 cycles → exactly one advance (cur_addr=6, cur_data=8'h16). No further change until the next step rising edge.
- en=1 and step rising edge in the same HOLD cycle at addr 7 → single advance to addr 8; the counter restarts from 0.
- clrn driven low in CAPTURE of addr 9 → all outputs return to reset values without waiting for a clock edge. After release with en=1 the scan restarts at addr 0.
